// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the buffered cluster router.
//   - Port index constants (N, S, W, E). Extra ports follow E.
//   - Legacy direction-mode enum used by existing cluster configuration.
//   - mode_to_mask(): converts a legacy mode into a 4-bit destination mask.
//     Bit order matches the port indices: bit0=N, bit1=S, bit2=W, bit3=E.
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int PORT_NORTH = 0;
    localparam int PORT_SOUTH = 1;
    localparam int PORT_WEST  = 2;
    localparam int PORT_EAST  = 3;

    typedef enum logic [3:0] {
        ALL,
        NORTH,
        SOUTH,
        WEST,
        EAST,
        EASTNORTH,
        EASTSOUTH,
        EASTWEST,
        WESTNORTH,
        WESTSOUTH,
        WESTEAST
    } dir_mode_e;

    function automatic logic [3:0] mode_to_mask(input dir_mode_e mode);
        logic [3:0] mask;
        mask = '0;
        case (mode)
            ALL:       mask = 4'b1111;
            NORTH:     mask[PORT_NORTH] = 1'b1;
            SOUTH:     mask[PORT_SOUTH] = 1'b1;
            WEST:      mask[PORT_WEST]  = 1'b1;
            EAST:      mask[PORT_EAST]  = 1'b1;
            EASTNORTH: begin mask[PORT_EAST] = 1'b1; mask[PORT_NORTH] = 1'b1; end
            EASTSOUTH: begin mask[PORT_EAST] = 1'b1; mask[PORT_SOUTH] = 1'b1; end
            EASTWEST,
            WESTEAST:  begin mask[PORT_EAST] = 1'b1; mask[PORT_WEST]  = 1'b1; end
            WESTNORTH: begin mask[PORT_WEST] = 1'b1; mask[PORT_NORTH] = 1'b1; end
            WESTSOUTH: begin mask[PORT_WEST] = 1'b1; mask[PORT_SOUTH] = 1'b1; end
            default:   mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/noc_router_buffered_if.sv
// -----------------------------------------------------------------------------
// noc_router_buffered_if
// Flit handshake bundle of the buffered router, all ports flattened.
//   in_data_i / in_valid_i / in_ready_o    : per-port input flits (to router)
//   out_data_o / out_valid_o / out_ready_i : per-port output flits (from router)
// Port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH] of the data vectors.
// Modports: slave = router side, master = traffic source/sink side.
// -----------------------------------------------------------------------------
interface noc_router_buffered_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 4
);
    logic [NUM_PORTS*DATA_WIDTH-1:0] in_data_i;
    logic [NUM_PORTS-1:0]            in_valid_i;
    logic [NUM_PORTS-1:0]            in_ready_o;
    logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_o;
    logic [NUM_PORTS-1:0]            out_valid_o;
    logic [NUM_PORTS-1:0]            out_ready_i;

    modport master (
        output in_data_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_data_o, out_valid_o
    );

    modport slave (
        input  in_data_i, in_valid_i, out_ready_i,
        output in_ready_o, out_data_o, out_valid_o
    );
endinterface

// File: rtl/noc_fifo.sv
// -----------------------------------------------------------------------------
// noc_fifo
// Synchronous FIFO, one per router input.
//   clk, reset      : clock, synchronous active-high reset
//   push, push_data : write request and flit (ignored when full)
//   pop             : read request (ignored when empty)
//   head            : flit at the read pointer
//   full, empty     : occupancy flags
// Pointers carry one extra wrap bit; equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
// -----------------------------------------------------------------------------
module noc_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking (<=) so every register sees
    // the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, so clearing data would only cost logic.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/noc_router_buffered.sv
// -----------------------------------------------------------------------------
// noc_router_buffered
// Buffered multicast cluster router with per-input FIFOs, registered outputs
// and round-robin allocation.
//   clk, reset   : clock, synchronous active-high reset
//   route_cfg_i  : destination mask per input, input i at [i*NUM_PORTS +: NUM_PORTS]
//   bus (slave)  : input/output flit handshakes for every port
//   drop_count_o : saturating count of flits discarded for an empty route
// A head flit fires only when every one of its destinations can load on the
// same edge, so multicast is all-or-nothing. A flit whose route (with its own
// port removed) is empty is discarded without claiming any output.
// -----------------------------------------------------------------------------
module noc_router_buffered
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] route_cfg_i,
    noc_router_buffered_if.slave           bus,
    output logic [CNT_WIDTH-1:0]           drop_count_o
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [NUM_PORTS-1:0] BIT0 = 1;

    logic [NUM_PORTS-1:0]  full, empty, push, pop;
    logic [DATA_WIDTH-1:0] head [NUM_PORTS];
    logic [NUM_PORTS-1:0]  eff [NUM_PORTS];
    logic [NUM_PORTS-1:0]  avail, claimed, fire, drop;
    logic [PTR_W-1:0]      src [NUM_PORTS];
    logic [PTR_W-1:0]      ptr, ptr_next, scan_idx;
    logic                  any_fire;
    logic [CNT_WIDTH:0]    drop_n, cnt_sum;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic [DATA_WIDTH-1:0] out_data_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]  out_valid_q;

    assign bus.in_ready_o  = ~full & {NUM_PORTS{~reset}};
    assign push            = bus.in_valid_i & bus.in_ready_o;
    assign pop             = fire | drop;
    assign bus.out_valid_o = out_valid_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        noc_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[i]),
            .push_data (bus.in_data_i[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop       (pop[i]),
            .head      (head[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );

        // Own port is masked out: a flit never turns back where it came from.
        assign eff[i]   = route_cfg_i[i*NUM_PORTS +: NUM_PORTS] & ~(BIT0 << i);
        assign avail[i] = !out_valid_q[i] || bus.out_ready_i[i];
        assign bus.out_data_o[i*DATA_WIDTH +: DATA_WIDTH] = out_data_q[i];
    end

    // Round-robin scan starting at ptr. Earlier-scanned inputs claim outputs
    // first; a later input fires only if all its destinations are still free.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the loop can leave a latch behind.
        claimed  = '0;
        fire     = '0;
        drop     = '0;
        any_fire = 1'b0;
        ptr_next = ptr;
        scan_idx = '0;
        for (int d = 0; d < NUM_PORTS; d++) src[d] = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_idx = PTR_W'((int'(ptr) + k) % NUM_PORTS);
            if (!empty[scan_idx]) begin
                if (eff[scan_idx] == '0) begin
                    drop[scan_idx] = 1'b1;
                end else if ((eff[scan_idx] & ~(avail & ~claimed)) == '0) begin
                    fire[scan_idx] = 1'b1;
                    claimed        = claimed | eff[scan_idx];
                    for (int d = 0; d < NUM_PORTS; d++) begin
                        if (eff[scan_idx][d]) src[d] = scan_idx;
                    end
                    if (!any_fire) begin
                        any_fire = 1'b1;
                        ptr_next = PTR_W'((int'(scan_idx) + 1) % NUM_PORTS);
                    end
                end
            end
        end
    end

    // Several inputs can drop on the same cycle; the sum saturates.
    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            drop_n = drop_n + {{CNT_WIDTH{1'b0}}, drop[i]};
        end
        cnt_sum  = {1'b0, drop_count_o} + drop_n;
        cnt_next = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= '0;
            out_valid_q  <= '0;
            drop_count_o <= '0;
            for (int d = 0; d < NUM_PORTS; d++) out_data_q[d] <= '0;
        end else begin
            ptr          <= ptr_next;
            drop_count_o <= cnt_next;
            for (int d = 0; d < NUM_PORTS; d++) begin
                if (claimed[d]) begin
                    out_data_q[d]  <= head[src[d]];
                    out_valid_q[d] <= 1'b1;
                end else if (bus.out_ready_i[d]) begin
                    out_valid_q[d] <= 1'b0;
                end
            end
        end
    end

endmodule
